dma_read_engine: RTL
====================

# dma_read_engine

Parametrised DMA read engine: on a software launch it arbitrates for the memory bus, streams `count_reg` words from RAM into the destination FIFO, then raises a completion flag. It sits between the bus arbiter/RAM on the source side and the DMA FIFO on the destination side. It is the next-generation read path with:

- configurable data, address and count widths;
- fixed- or incrementing-address sources;
- a bounded burst length, so other masters are not starved;
- a zero-count error flag.

## Interface
Parameters:
- `DATA_W`, 32: word width; address stride is DATA_W/8 bytes.
- `ADDR_W`, 32: address width.
- `CNT_W`, 16: transfer-count width.
- `BURST_MAX`, 8: maximum beats per bus ownership, ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `ctrl_reg`  in  4  control register bits:
  - bit0 active;
  - bit1 mode (0 = read, engine responds only to 0);
  - bit2 inc_src (0 = fixed address, 1 = increment);
  - bit3 abort (see Configuration).
- `addr_reg`  in  ADDR_W  start address.
- `count_reg`  in  CNT_W  number of words.
- `mem_request`  out  1  bus request to arbiter.
- `mem_grant`  in  1  bus grant.
- `mem_addr`  out  ADDR_W  read address; 0 outside READ.
- `rx_enable`  out  1  high in READ.
- `mem_rd_data`  in  DATA_W  same-cycle read data.
- `full`  in  1  FIFO full.
- `wr_enable`  out  1  FIFO write strobe.
- `wr_data`  out  DATA_W  FIFO write data; 0 when wr_enable low.
- `busy`  out  1  state != IDLE.
- `rx_done`  out  1  sticky completion flag.
- `err_zero`  out  1  sticky: launched with count 0.
- `aborted`  out  1  sticky: transfer aborted.

## Operation
- **Launch:** rising edge of `ctrl_reg[0]` with `ctrl_reg[1]==0`, seen while in IDLE.
  - Edge detection uses one registered copy of bit0.
  - A held-high active bit never relaunches.
- **On launch:** capture `addr_reg` into cur_addr and `count_reg` into cur_count; clear `rx_done`, `err_zero` and `aborted`; clear beat_cnt.
  - If count_reg==0: go to DONE and set `err_zero`; no bus request is made.
- **States:** IDLE, BUS_REQ, READ, RELEASE, DONE.
- **BUS_REQ:** `mem_request`=1. Move to READ when `mem_grant && !full`; otherwise stay.
- **READ:** `mem_request`=1, `rx_enable`=1, `mem_addr`=cur_addr.
  - A beat occurs on a cycle with `mem_grant && !full`. On a beat:
    - `wr_enable`=1 and `wr_data`=`mem_rd_data`, combinationally;
    - cur_count decrements;
    - cur_addr += DATA_W/8 if inc_src, else holds;
    - beat_cnt increments.
  - Next state after a beat:
    - cur_count==1 → DONE;
    - else beat_cnt==BURST_MAX-1 → RELEASE;
    - else stay in READ.
  - `mem_grant` low → BUS_REQ, with no beat and no update.
  - `full` high with grant present → stay in READ and stall.
- **RELEASE:** `mem_request`=0 for exactly one cycle, clear beat_cnt, go to BUS_REQ.
- **DONE:** set `rx_done`, go to IDLE.
- **Arithmetic:** address wraps modulo 2^ADDR_W. `ctrl_reg[2]` is sampled live on each beat.
- `ctrl_reg[1]` going high mid-transfer is ignored; mode is checked only at launch.

## Timing
- **Reset values:**
  - all state registers are IDLE/0;
  - all outputs are 0: `mem_request`, `mem_addr`, `rx_enable`, `wr_enable`, `wr_data`, `busy`, `rx_done`, `err_zero`, `aborted`.
- **Launch:** active bit rises and is sampled at edge N → `busy` and `mem_request` high from N+1.
- **Grant:** grant at edge M in BUS_REQ → READ at M+1; the first beat can occur in the M+1 cycle.
- **Throughput:** one word per cycle while granted and not full.
- **Completion:** `rx_done` rises one cycle after the last beat's edge, then the engine enters IDLE. It holds until the next launch.
- **Reset mid-transfer:** immediate return to IDLE with all outputs 0; no partial-done flag.

## Configuration
- Macro `DMA_READ_ABORT_EN`:
  - **Defined:** `ctrl_reg[3]` high in BUS_REQ, READ or RELEASE forces DONE on the next edge and sets `aborted` together with `rx_done`. `wr_enable` is suppressed in the abort cycle.
  - **Undefined:** bit3 is ignored and `aborted` is tied to 0.

## Structure
- **Package `dma_read_pkg`:** state encoding and ctrl bit index constants (CTRL_ACTIVE=0, CTRL_MODE=1, CTRL_INC=2, CTRL_ABORT=3).
- **Sub-module `dma_addr_gen`:** holds cur_addr, cur_count and beat_cnt, with load/step/clear inputs and last/burst_end outputs. The FSM and flag logic stay in the top module.

## Test plan
- **Basic:** DATA_W=32, addr 0x100, count 4, inc 1, grant held, full 0 → 4 writes at 0x100/104/108/10C, `rx_done` high one cycle after the 4th.
- **Fixed address:** inc 0, count 3 → 3 writes all at 0x200, data matches RAM stream order.
- **Burst limit:** BURST_MAX=2, count 5 → `mem_request` low for exactly one cycle after beats 2 and 4, 5 writes total.
- **Backpressure / grant loss:**
  - `full` high for 3 cycles mid-transfer → no write, address and count held;
  - grant dropped → return to BUS_REQ, transfer resumes with no lost or duplicated word.
- **Zero count / relaunch:** count 0 → `err_zero` and `rx_done` set, `mem_request` never high. Holding active high after done → no relaunch.
- **Abort / reset** (ABORT_EN): abort after 2 of 8 beats → `aborted` and `rx_done` set, 2 writes only. Reset asserted mid-READ → all outputs 0 the same cycle.

Source files
------------

// File: rtl/dma_read_pkg.sv
// Shared definitions for the DMA read engine: FSM encoding, ctrl_reg bit
// positions and a sizing helper for the burst beat counter.
package dma_read_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUS_REQ = 3'd1,
        ST_READ    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int CTRL_ACTIVE = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_INC    = 2;
    localparam int CTRL_ABORT  = 3;

    // Counter width able to hold 0 .. burst_max-1 (at least one bit).
    function automatic int beat_cnt_width(input int burst_max);
        return (burst_max > 1) ? $clog2(burst_max) : 1;
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Address, remaining-word and burst-beat bookkeeping for the DMA read engine.
// The FSM in dma_read_engine drives load/step/clear and consumes last/burst_end.
module dma_addr_gen
    import dma_read_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  start_count,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last,
    output logic              burst_end
);

    localparam int BW = beat_cnt_width(BURST_MAX);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);
    localparam logic [BW-1:0]     BEAT_LAST = BW'(BURST_MAX - 1);

    logic [CNT_W-1:0] cur_count;
    logic [BW-1:0]    beat_cnt;

    // Address arithmetic wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr  <= '0;
            cur_count <= '0;
            beat_cnt  <= '0;
        end else if (load) begin
            cur_addr  <= start_addr;
            cur_count <= start_count;
            beat_cnt  <= '0;
        end else begin
            if (step) begin
                cur_count <= cur_count - CNT_W'(1);
                beat_cnt  <= beat_cnt + BW'(1);
                if (inc) begin
                    cur_addr <= cur_addr + STRIDE;
                end
            end
            if (clear) begin
                beat_cnt <= '0;
            end
        end
    end

    assign last      = (cur_count == CNT_W'(1));
    assign burst_end = (beat_cnt == BEAT_LAST);

endmodule

// File: rtl/dma_read_engine.sv
// DMA read engine: arbitrates for the memory bus and streams count_reg words
// into the destination FIFO in bounded bursts. Optional abort: DMA_READ_ABORT_EN.
module dma_read_engine
    import dma_read_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ctrl_reg,
    input  logic [ADDR_W-1:0] addr_reg,
    input  logic [CNT_W-1:0]  count_reg,
    output logic              mem_request,
    input  logic              mem_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rx_enable,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              full,
    output logic              wr_enable,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              rx_done,
    output logic              err_zero,
    output logic              aborted
);

    state_t            state;
    state_t            state_nxt;
    logic              active_q;
    logic              launch;
    logic              beat;
    logic              abort_req;
    logic [ADDR_W-1:0] cur_addr;
    logic              last;
    logic              burst_end;

    assign launch = (state == ST_IDLE) && ctrl_reg[CTRL_ACTIVE] && !active_q
                    && !ctrl_reg[CTRL_MODE];

`ifdef DMA_READ_ABORT_EN
    logic abort_pend;
    logic aborted_q;

    assign abort_req = ctrl_reg[CTRL_ABORT] &&
                       ((state == ST_BUS_REQ) || (state == ST_READ) || (state == ST_RELEASE));
    assign aborted   = aborted_q;
`else
    logic unused_abort_bit;

    assign unused_abort_bit = ctrl_reg[CTRL_ABORT];
    assign abort_req        = 1'b0;
    assign aborted          = 1'b0;
`endif

    // Handshake: a beat transfers one word when the engine is in READ, the
    // arbiter grants the bus and the FIFO is not full; the RAM answers in the
    // same cycle and the word is written to the FIFO in that cycle.
    assign beat = (state == ST_READ) && mem_grant && !full && !abort_req;

    dma_addr_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .BURST_MAX (BURST_MAX)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (launch),
        .step        (beat),
        .clear       (state == ST_RELEASE),
        .inc         (ctrl_reg[CTRL_INC]),
        .start_addr  (addr_reg),
        .start_count (count_reg),
        .cur_addr    (cur_addr),
        .last        (last),
        .burst_end   (burst_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = (count_reg == '0) ? ST_DONE : ST_BUS_REQ;
                end
            end
            ST_BUS_REQ: begin
                if (mem_grant && !full) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (!mem_grant) begin
                    state_nxt = ST_BUS_REQ;
                end else if (beat) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                    end else if (burst_end) begin
                        state_nxt = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: state_nxt = ST_BUS_REQ;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (abort_req) begin
            state_nxt = ST_DONE;
        end
    end

    always_comb begin
        mem_request = (state == ST_BUS_REQ) || (state == ST_READ);
        rx_enable   = (state == ST_READ);
        mem_addr    = (state == ST_READ) ? cur_addr : '0;
        wr_enable   = beat;
        wr_data     = beat ? mem_rd_data : '0;
        busy        = (state != ST_IDLE);
    end

    // Sticky status flags; a launch clears them, DONE publishes completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q   <= 1'b0;
            rx_done    <= 1'b0;
            err_zero   <= 1'b0;
`ifdef DMA_READ_ABORT_EN
            abort_pend <= 1'b0;
            aborted_q  <= 1'b0;
`endif
        end else begin
            active_q <= ctrl_reg[CTRL_ACTIVE];
            if (launch) begin
                rx_done  <= 1'b0;
                err_zero <= (count_reg == '0);
`ifdef DMA_READ_ABORT_EN
                abort_pend <= 1'b0;
                aborted_q  <= 1'b0;
`endif
            end
`ifdef DMA_READ_ABORT_EN
            if (abort_req) begin
                abort_pend <= 1'b1;
            end
            if (state == ST_DONE) begin
                aborted_q <= abort_pend;
            end
`endif
            if (state == ST_DONE) begin
                rx_done <= 1'b1;
            end
        end
    end

endmodule
